// File: rtl/c7bexu_ecl_pkg.sv
// c7bexu_ecl_pkg -- shared types and constants for the c7bexu execute-stage
// control logic (c7bexu_ecl_mc and its per-channel FSM c7bexu_ecl_ch).
//   ch_state_e   : per-channel tracking state
//   CAUSE_*      : except_cause encodings
//   csr_cnt_w()  : CSR stall counter width for a given CSR_STALL_CYCLES
package c7bexu_ecl_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_state_e;

  localparam logic [1:0] CAUSE_ALE     = 2'd0;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd1;
  localparam logic [1:0] CAUSE_ECC     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Counter must hold the value CSR_STALL_CYCLES itself (1..15).
  function automatic int csr_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/c7bexu_ecl_if.sv
// c7bexu_ecl_if -- pipeline <-> execution-control bundle.
//   master : pipeline side (drives starts/completions/flush, sees stalls/report)
//   slave  : c7bexu_ecl_mc side
// Inputs to the ECL : ch_vld_e, ch_done, ch_except, ch_except_code, csr_vld_e, flush
// Outputs of the ECL: stall_ifu, stall_reg_mw, ch_busy, except_vld, except_ch, except_cause
interface c7bexu_ecl_if #(
  parameter int NUM_CH   = 2,
  parameter int CH_IDX_W = 3
) ();
  logic [NUM_CH-1:0]      ch_vld_e;
  logic [NUM_CH-1:0]      ch_done;
  logic [NUM_CH-1:0]      ch_except;
  logic [NUM_CH-1:0][1:0] ch_except_code;
  logic                   csr_vld_e;
  logic                   flush;

  logic                   stall_ifu;
  logic                   stall_reg_mw;
  logic [NUM_CH-1:0]      ch_busy;
  logic                   except_vld;
  logic [CH_IDX_W-1:0]    except_ch;
  logic [1:0]             except_cause;

  modport master (
    output ch_vld_e, ch_done, ch_except, ch_except_code, csr_vld_e, flush,
    input  stall_ifu, stall_reg_mw, ch_busy, except_vld, except_ch, except_cause
  );

  modport slave (
    input  ch_vld_e, ch_done, ch_except, ch_except_code, csr_vld_e, flush,
    output stall_ifu, stall_reg_mw, ch_busy, except_vld, except_ch, except_cause
  );
endinterface

// File: rtl/c7bexu_ecl_ch.sv
// c7bexu_ecl_ch -- one long-latency channel tracker (IDLE/BUSY) with an
// optional watchdog enabled by macro C7BEXU_ECL_TIMEOUT_EN.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : kill tracking (wins over everything else)
//   vld_e           : start pulse
//   done, except    : normal / exceptional completion
//   except_code     : cause carried with except
//   busy            : registered BUSY status
//   fire, cause     : exception (or timeout) accepted this cycle, and its cause
module c7bexu_ecl_ch
  import c7bexu_ecl_pkg::*;
`ifdef C7BEXU_ECL_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       vld_e,
  input  logic       done,
  input  logic       except,
  input  logic [1:0] except_code,
  output logic       busy,
  output logic       fire,
  output logic [1:0] cause
);

  ch_state_e state_q;
  logic      tmo;

  assign busy = (state_q == CH_BUSY);

`ifdef C7BEXU_ECL_TIMEOUT_EN
  localparam int AGE_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [AGE_W-1:0] age_q;

  // age_q counts completed busy cycles; the TIMEOUT_CYCLES-th busy cycle
  // trips unless a real completion arrives in that same cycle.
  assign tmo = busy & ~except & ~done & ~flush &
               (age_q == AGE_W'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle, so entry to BUSY always starts from zero;
  // a back-to-back restart clears it explicitly.
  always_ff @(posedge clk) begin
    if (reset || !busy || (done && vld_e)) age_q <= '0;
    else                                   age_q <= age_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: if (vld_e) state_q <= CH_BUSY;
        // except drops a same-cycle restart; done+vld_e keeps BUSY
        CH_BUSY: if (except || tmo || (done && !vld_e)) state_q <= CH_IDLE;
        default: state_q <= CH_IDLE;
      endcase
    end
  end

  assign fire  = (busy & except & ~flush) | tmo;
  assign cause = except ? except_code : CAUSE_TIMEOUT;

  // A second start while an op is outstanding is a pipeline protocol bug.
  a_no_restart: assert property (@(posedge clk) disable iff (reset)
    !(busy && vld_e && !done && !except && !flush));

endmodule

// File: rtl/c7bexu_ecl_mc.sv
// c7bexu_ecl_mc -- multi-channel execution control for the c7bexu E stage.
// Tracks NUM_CH long-latency units (one outstanding op each), a CSR
// serialisation stall, and produces fetch / M-W stalls plus a registered,
// lowest-index-first exception report.
// Optional macro: C7BEXU_ECL_TIMEOUT_EN (per-channel watchdog, cause 3).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : c7bexu_ecl_if.slave (starts, completions, CSR, flush in;
//                stall_ifu, stall_reg_mw, ch_busy, except_* out)
module c7bexu_ecl_mc
  import c7bexu_ecl_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int CSR_STALL_CYCLES = 2,
  parameter int CH_IDX_W         = 3,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic          clk,
  input  logic          reset,
  c7bexu_ecl_if.slave   bus
);

  localparam int CW = csr_cnt_w(CSR_STALL_CYCLES);

  if (NUM_CH < 1 || NUM_CH > 8 || (1 << CH_IDX_W) < NUM_CH ||
      CSR_STALL_CYCLES < 1 || CSR_STALL_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("c7bexu_ecl_mc: parameter out of range");
  end

  logic [NUM_CH-1:0]      busy;
  logic [NUM_CH-1:0]      fire;
  logic [NUM_CH-1:0][1:0] cause;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    c7bexu_ecl_ch
`ifdef C7BEXU_ECL_TIMEOUT_EN
      #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_ch (
      .clk         (clk),
      .reset       (reset),
      .flush       (bus.flush),
      .vld_e       (bus.ch_vld_e[g]),
      .done        (bus.ch_done[g]),
      .except      (bus.ch_except[g]),
      .except_code (bus.ch_except_code[g]),
      .busy        (busy[g]),
      .fire        (fire[g]),
      .cause       (cause[g])
    );
  end

  // CSR serialisation counter; a new CSR reloads the full window.
  logic [CW-1:0] csr_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.flush)    csr_cnt <= '0;
    else if (bus.csr_vld_e)    csr_cnt <= CW'(CSR_STALL_CYCLES);
    else if (csr_cnt != '0)    csr_cnt <= csr_cnt - 1'b1;
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  logic [CH_IDX_W-1:0] sel_ch;
  logic [1:0]          sel_cause;

  always_comb begin
    sel_ch    = '0;
    sel_cause = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fire[i]) begin
        sel_ch    = CH_IDX_W'(i);
        sel_cause = cause[i];
      end
    end
  end

  logic                except_vld_q;
  logic [CH_IDX_W-1:0] except_ch_q;
  logic [1:0]          except_cause_q;

  // fire is already suppressed by flush inside each channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      except_vld_q   <= 1'b0;
      except_ch_q    <= '0;
      except_cause_q <= '0;
    end else begin
      except_vld_q   <= |fire;
      except_ch_q    <= sel_ch;
      except_cause_q <= sel_cause;
    end
  end

  assign bus.ch_busy      = busy;
  // Fetch stall is built only from state, never from this cycle's inputs.
  assign bus.stall_ifu    = (|busy) | (csr_cnt != '0);
  // M/W may advance in the very cycle a tracked op completes.
  assign bus.stall_reg_mw = (|busy) & ~(|(bus.ch_done & busy));
  assign bus.except_vld   = except_vld_q;
  assign bus.except_ch    = except_ch_q;
  assign bus.except_cause = except_cause_q;

endmodule

// File: tb/tb_c7bexu_ecl_mc.sv
module tb_c7bexu_ecl_mc;
  localparam int NC  = 4;
  localparam int IW  = 3;
  localparam int CSR = 2;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  c7bexu_ecl_if #(.NUM_CH(NC), .CH_IDX_W(IW)) bus ();

  c7bexu_ecl_mc #(
    .NUM_CH(NC), .CSR_STALL_CYCLES(CSR), .CH_IDX_W(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which channels hold an op, how many cycles each has
  // been busy, the remaining CSR stall, and the report due next cycle.
  bit m_busy [NC];
  int m_n    [NC];
  int m_csr;
  bit m_xv;
  int m_xch;
  int m_xc;

  task automatic step(input bit rst, input logic [NC-1:0] vld, input logic [NC-1:0] done,
                      input logic [NC-1:0] exc, input logic [2*NC-1:0] code,
                      input bit csr, input bit fl);
    logic [NC-1:0] eb;
    bit any_busy, any_done, fired, rep;
    int cs;
    @(negedge clk);
    reset              = rst;
    bus.ch_vld_e       = vld;
    bus.ch_done        = done;
    bus.ch_except      = exc;
    bus.ch_except_code = code;
    bus.csr_vld_e      = csr;
    bus.flush          = fl;
    #1;
    any_busy = 0;
    any_done = 0;
    for (int c = 0; c < NC; c++) begin
      eb[c] = m_busy[c];
      if (m_busy[c]) any_busy = 1;
      if (m_busy[c] && done[c]) any_done = 1;
    end
    chk("ch_busy",      32'(bus.ch_busy),      32'(eb));
    chk("stall_ifu",    32'(bus.stall_ifu),    32'(any_busy || m_csr != 0));
    chk("stall_reg_mw", 32'(bus.stall_reg_mw), 32'(any_busy && !any_done));
    chk("except_vld",   32'(bus.except_vld),   32'(m_xv));
    chk("except_ch",    32'(bus.except_ch),    32'(m_xch));
    chk("except_cause", 32'(bus.except_cause), 32'(m_xc));

    m_xv  = 0;
    m_xch = 0;
    m_xc  = 0;
    fired = 0;
    if (rst || fl) begin
      for (int c = 0; c < NC; c++) begin
        m_busy[c] = 0;
        m_n[c]    = 0;
      end
      m_csr = 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        rep = 0;
        cs  = 0;
        if (m_busy[c]) begin
          if (exc[c]) begin
            m_busy[c] = 0; rep = 1; cs = int'(code[2*c +: 2]);
          end else if (done[c]) begin
            m_busy[c] = vld[c]; m_n[c] = 1;
`ifdef C7BEXU_ECL_TIMEOUT_EN
          end else if (m_n[c] == TO) begin
            m_busy[c] = 0; rep = 1; cs = 3;
`endif
          end else begin
            m_n[c]++;
          end
        end else if (vld[c]) begin
          m_busy[c] = 1; m_n[c] = 1;
        end
        if (rep && !fired) begin
          fired = 1; m_xv = 1; m_xch = c; m_xc = cs;
        end
      end
      if (csr)            m_csr = CSR;
      else if (m_csr > 0) m_csr--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.ch_vld_e       = '0;
    bus.ch_done        = '0;
    bus.ch_except      = '0;
    bus.ch_except_code = '0;
    bus.csr_vld_e      = 1'b0;
    bus.flush          = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_busy[c] = 0;
      m_n[c]    = 0;
    end
    m_csr = 0; m_xv = 0; m_xch = 0; m_xc = 0;
    repeat (3) @(posedge clk);

    // quiet after reset
    idle(5);
    // CSR stall window
    step(0, '0, '0, '0, '0, 1, 0);
    idle(4);
    // CSR reload while counting
    step(0, '0, '0, '0, '0, 1, 0);
    step(0, '0, '0, '0, '0, 1, 0);
    idle(4);
    // ch0 op completing 3 cycles after start
    step(0, 4'b0001, '0, '0, '0, 0, 0);
    idle(2);
    step(0, '0, 4'b0001, '0, '0, 0, 0);
    idle(2);
    // simultaneous exceptions ch0 (buserr) / ch1 (ecc)
    step(0, 4'b0011, '0, '0, '0, 0, 0);
    step(0, '0, '0, 4'b0011, 8'b0000_1001, 0, 0);
    idle(2);
    // simultaneous exceptions ch2 (ale) / ch3 (ecc): lowest is ch2
    step(0, 4'b1100, '0, '0, '0, 0, 0);
    step(0, '0, '0, 4'b1100, 8'b1000_0000, 0, 0);
    idle(2);
    // flush wins over a same-cycle exception
    step(0, 4'b0010, '0, '0, '0, 0, 0);
    step(0, '0, '0, 4'b0010, 8'b0000_0100, 0, 1);
    idle(2);
    // back-to-back op, then except dropping a restart, then idle done/except
    step(0, 4'b0001, '0, '0, '0, 0, 0);
    step(0, 4'b0001, 4'b0001, '0, '0, 0, 0);
    step(0, 4'b0001, '0, 4'b0001, 8'b0000_0010, 0, 0);
    step(0, '0, 4'b0110, 4'b1000, 8'b1100_0000, 0, 0);
    idle(2);
    // reset mid-operation
    step(0, 4'b1011, '0, '0, '0, 1, 0);
    step(1, '0, '0, '0, '0, 0, 0);
    idle(3);
`ifdef C7BEXU_ECL_TIMEOUT_EN
    // watchdog on ch0
    step(0, 4'b0001, '0, '0, '0, 0, 0);
    idle(TO + 3);
`endif

    // randomized legal traffic
    for (int k = 0; k < 3000; k++) begin
      logic [NC-1:0]   v, d, e;
      logic [2*NC-1:0] cd;
      bit r, f, cs;
      r  = ($urandom_range(99) == 0);
      f  = ($urandom_range(49) == 0);
      cs = ($urandom_range(9) == 0);
      cd = (2*NC)'($urandom);
      for (int c = 0; c < NC; c++) begin
        d[c] = ($urandom_range(4) == 0);
        e[c] = ($urandom_range(11) == 0);
        if (m_busy[c]) v[c] = (d[c] || e[c]) && ($urandom_range(1) == 1);
        else           v[c] = ($urandom_range(2) == 0);
      end
      step(r, v, d, e, cd, cs, f);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
